d_mem_sized: RTL and testbench
==============================

// Module: d_mem_sized
// PURPOSE
//  Parametrised data memory for the MEM stage: byte/half/word loads and stores,
//  signed or unsigned load extension, registered 1-cycle read, req/rsp handshake.
//  Storage is word-organised with byte enables. Misaligned accesses that span two
//  words optionally complete as a two-beat split. Range and size faults are
//  reported on rsp_err instead of corrupting memory.
// PARAMETERS
//  DEPTH_WORDS      128  number of 32-bit words (byte capacity = 4*DEPTH_WORDS)
//  ADDR_W           32   request address width (byte address)
//  ALLOW_MISALIGNED 0    1: word-spanning access splits into 2 beats; 0: faults
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       async, active-high; clears control state, not RAM
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted on clk edge when valid&ready
//  req_write    in   1       1 store, 0 load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 reserved (fault)
//  req_unsigned in   1       load: 1 zero-extend, 0 sign-extend (ignored for word)
//  req_addr     in   ADDR_W  byte address, little-endian
//  req_wdata    in   32      store data, right-aligned (byte in [7:0], half [15:0])
//  rsp_valid    out  1       one-cycle pulse per accepted request (loads and stores)
//  rsp_rdata    out  32      load result, extended; 0 for stores and faults
//  rsp_err      out  1       qualifies rsp_valid: request faulted, no side effects
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
//   RAM contents undefined after power-up and untouched by reset.
//  States: IDLE (req_ready=1), SPLIT (req_ready=0). Responses have no backpressure.
//  nbytes = 1/2/4 by size. end = addr+nbytes-1, computed in ADDR_W+1 bits (no wrap).
//  Fault if: size==11, or end >= 4*DEPTH_WORDS, or access spans two words
//   (addr[1:0]+nbytes > 4) with ALLOW_MISALIGNED=0. Fault: no RAM write;
//   rsp_valid=1, rsp_err=1, rsp_rdata=0 the cycle after accept; stays IDLE.
//  Non-spanning access accepted at edge N: store commits bytes at edge N;
//   rsp_valid at N+1. Load reads word at edge N; rsp_rdata valid with rsp_valid
//   at N+1. Back-to-back accepts allowed (one request per cycle throughput).
//  Spanning access (ALLOW_MISALIGNED=1): edge N handles low-word bytes and moves to
//   SPLIT; edge N+1 handles high-word bytes, returns to IDLE; rsp_valid at N+2.
//   req_ready low during SPLIT; requests held by master.
//  Load after store to same bytes on next accept returns the new data.
//  Extension: byte -> bit7 replicated, half -> bit15 replicated when signed;
//   zero-filled when unsigned.
//  Reset during SPLIT: low-word bytes of a store are already committed, high-word
//   bytes are not written; no response is produced for the aborted request.
//  rsp_rdata/rsp_err hold 0 in cycles where rsp_valid=0.
// TESTING
//  1. Store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, err=0,
//     rsp 1 cycle after each accept.
//  2. Load half @0x12 signed -> 0xFFFFDEAD; unsigned -> 0x0000DEAD; load byte
//     @0x10 signed -> 0xFFFFFFEF; store byte 0x7F @0x11, load word @0x10 ->
//     0xDEAD7FEF.
//  3. ALLOW_MISALIGNED=1: store word 0x11223344 @0x1E; req_ready low 1 cycle,
//     rsp at N+2; load words @0x1C/@0x20 -> 0x3344xxxx / 0xxxxx1122.
//  4. ALLOW_MISALIGNED=0: load word @0x1E -> rsp_err=1, rdata=0; store half @0x1F
//     -> err=1, memory unchanged.
//  5. DEPTH_WORDS=128: load word @0x1FC ok; half @0x1FF, word @0xFFFFFFFE,
//     size=11 -> err=1.
//  6. Assert reset mid-SPLIT of spanning store: outputs 0 immediately, no rsp,
//     low-word bytes written, high-word bytes old; next request accepted normally.

Source files
------------

// File: rtl/d_mem_sized.sv
`default_nettype none
// ============================================================================
// Module   : d_mem_sized
// Purpose  : MEM-stage data memory. Byte/half/word loads and stores with
//            signed/unsigned load extension, 1-cycle registered response and a
//            req/rsp handshake. Storage is word-organised with byte enables.
//            Word-spanning accesses either fault or complete as a two-beat
//            split (ALLOW_MISALIGNED). Range/size faults report on rsp_err
//            and never touch memory.
// Ports    : clk, reset (async, active-high; control state only, not RAM)
//            req_valid/req_ready handshake; req_write, req_size, req_unsigned,
//            req_addr (byte, little-endian), req_wdata (right-aligned)
//            rsp_valid pulse per accepted request; rsp_rdata (0 unless a
//            successful load); rsp_err (faulted request)
// Revision : 1.0 - initial release
// ============================================================================
module d_mem_sized #(
  parameter int DEPTH_WORDS      = 128,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(4*DEPTH_WORDS);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  // ---- request decode ------------------------------------------------------
  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic [3:0]        mask;
  logic [ADDR_W:0]   req_end;
  logic              spans;
  logic              fault;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        be_wide;
  logic [63:0]       wd_wide;

  assign off = req_addr[1:0];
  assign idx = req_addr[IDX_W+1:2];

  always_comb begin
    nbytes = 3'd4;
    mask   = 4'b1111;
    case (req_size)
      2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase
  end

  // Last byte computed one bit wider so addresses near the top never wrap.
  assign req_end = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, nbytes}
                 - {{ADDR_W{1'b0}}, 1'b1};
  assign spans   = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
  assign fault   = (req_size == 2'b11) | (req_end >= BYTE_LIMIT)
                 | (spans & (ALLOW_MISALIGNED == 0));

  // Store data and enables placed across a two-word window; the low half
  // targets the addressed word, the high half the following word.
  assign be_wide = {4'b0000, mask} << off;
  assign wd_wide = {32'd0, req_wdata} << {off, 3'b000};

  // ---- split context (captured on the first beat) --------------------------
  logic [IDX_W-1:0] s_idx;
  logic [1:0]       s_off;
  logic [1:0]       s_size;
  logic             s_uns;
  logic             s_write;
  logic [31:0]      s_lo;
  logic [31:0]      s_hi_data;
  logic [3:0]       s_hi_be;

  // Single read port: addressed word in IDLE, the following word in SPLIT.
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  assign rd_idx  = (state == SPLIT) ? (s_idx + IDX_W'(1)) : idx;
  assign rd_word = mem[rd_idx];

  function automatic logic [31:0] fmt_load(input logic [63:0] pair,
                                           input logic [1:0]  o,
                                           input logic [1:0]  sz,
                                           input logic        uns);
    logic [31:0] w;
    w = 32'(pair >> {o, 3'b000});
    case (sz)
      2'b00:   fmt_load = {{24{~uns & w[7]}},  w[7:0]};
      2'b01:   fmt_load = {{16{~uns & w[15]}}, w[15:0]};
      default: fmt_load = w;
    endcase
  endfunction

  // ---- next state / write port / next response -----------------------------
  logic             we;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             rsp_valid_nxt;
  logic             rsp_err_nxt;
  logic [31:0]      rsp_rdata_nxt;

  always_comb begin
    state_nxt     = state;
    we            = 1'b0;
    wr_idx        = idx;
    wr_data       = wd_wide[31:0];
    wr_be         = be_wide[3:0];
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end else begin
            we = req_write;
            if (spans) begin
              state_nxt = SPLIT;
            end else begin
              rsp_valid_nxt = 1'b1;
              if (!req_write)
                rsp_rdata_nxt = fmt_load({32'd0, rd_word}, off, req_size, req_unsigned);
            end
          end
        end
      end
      SPLIT: begin
        state_nxt     = IDLE;
        we            = s_write;
        wr_idx        = s_idx + IDX_W'(1);
        wr_data       = s_hi_data;
        wr_be         = s_hi_be;
        rsp_valid_nxt = 1'b1;
        if (!s_write)
          rsp_rdata_nxt = fmt_load({rd_word, s_lo}, s_off, s_size, s_uns);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid && !fault && spans) begin
      s_idx     <= idx;
      s_off     <= off;
      s_size    <= req_size;
      s_uns     <= req_unsigned;
      s_write   <= req_write;
      s_lo      <= rd_word;
      s_hi_data <= wd_wide[63:32];
      s_hi_be   <= be_wide[7:4];
    end
  end

  // RAM has no reset; writes are blocked while reset is held so an aborted
  // split or a request presented during reset cannot commit.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_mem_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_d_mem_sized
// Purpose  : Self-checking bench for d_mem_sized. Two instances share a clock
//            and reset: index 0 allows split misaligned accesses, index 1
//            faults them. A byte-array model predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_mem_sized;
  localparam int DEPTH = 128;
  localparam int MEMB  = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  d_mem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_mis (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  d_mem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_al (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mm [2][MEMB];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rdata [2];
  logic        last_err   [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, {2'b00, got}, {2'b00, exp});
  endtask

  // Per-cycle compare of both instances against the scheduled responses.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (chk_en && !reset) begin
      for (int k = 0; k < 2; k++) begin
        have = 1'b0;
        if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        if (have)
          chk($sformatf("rsp dut%0d cyc%0d", k, cyc),
              {rsp_valid[k], rsp_err[k], rsp_rdata[k]}, {1'b1, e.err, e.rdata});
        else
          chk($sformatf("idle dut%0d cyc%0d", k, cyc),
              {rsp_valid[k], rsp_err[k], rsp_rdata[k]}, 34'd0);
        if (rsp_valid[k]) begin
          last_rdata[k] = rsp_rdata[k];
          last_err[k]   = rsp_err[k];
        end
      end
    end
  end

  // Behavioural model: byte-addressed little-endian memory.
  task automatic model(input int k, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output exp_t e, output bit span);
    int          nb;
    longint      last;
    bit          flt;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'({32'd0, a}) + longint'(nb) - 1;
    span = (int'(a[1:0]) + nb) > 4;
    flt  = (sz == 2'd3) || (last >= longint'(MEMB)) || (span && k == 1);
    e.err   = flt;
    e.rdata = 32'd0;
    e.due   = 0;
    if (flt) begin
      span = 1'b0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mm[k][int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[k][int'(a) + i];
      if (!uns && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
      if (!uns && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
      e.rdata = v;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Called at a negedge; returns at a negedge with req_valid low.
  task automatic issue(input int k, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   span;
    int   waited;
    req_valid[k] = 1'b1; req_write[k] = w; req_size[k] = sz;
    req_unsigned[k] = uns; req_addr[k] = a; req_wdata[k] = wd;
    waited = 0;
    while (!req_ready[k] && waited < 10) begin cycles(1); waited++; end
    if (!req_ready[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept timeout dut%0d: ready %b, required 1", k, req_ready[k]);
      req_valid[k] = 1'b0;
      return;
    end
    model(k, w, sz, uns, a, wd, e, span);
    e.due = cyc + 1 + (span ? 1 : 0);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    cycles(1);
    if (span) begin
      chk("ready low in split", {33'd0, req_ready[k]}, 34'd0);
      cycles(1);
    end
    req_valid[k] = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      last_rdata[k] = 32'd0; last_err[k] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset ready/valid/err", {31'd0, req_ready[k], rsp_valid[k], rsp_err[k]}, 34'b100);
      lit("reset rdata", rsp_rdata[k], 32'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Fill both memories so the model is fully known.
    for (int k = 0; k < 2; k++)
      for (int wi = 0; wi < DEPTH; wi++) issue(k, 1'b1, 2'd2, 1'b0, 32'(wi * 4), $urandom);

    // Word store/load, then sub-word loads with extension.
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0); cycles(1);
    lit("word load 0x10", last_rdata[0], 32'hDEADBEEF);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0); cycles(1);
    lit("half signed 0x12", last_rdata[0], 32'hFFFFDEAD);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0); cycles(1);
    lit("half unsigned 0x12", last_rdata[0], 32'h0000DEAD);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h10, 32'd0); cycles(1);
    lit("byte signed 0x10", last_rdata[0], 32'hFFFFFFEF);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000007F);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0); cycles(1);
    lit("word after byte store", last_rdata[0], 32'hDEAD7FEF);

    // Split store across words.
    issue(0, 1'b1, 2'd2, 1'b0, 32'h1C, 32'hAAAAAAAA);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hBBBBBBBB);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h1E, 32'h11223344);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1C, 32'd0); cycles(1);
    lit("split low word", last_rdata[0], 32'h3344AAAA);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0); cycles(1);
    lit("split high word", last_rdata[0], 32'hBBBB1122);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1E, 32'd0); cycles(1);
    lit("split load", last_rdata[0], 32'h11223344);

    // Misaligned faults with splitting disabled.
    issue(1, 1'b1, 2'd2, 1'b0, 32'h1C, 32'hCCCCCCCC);
    issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDDDDDDDD);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h1E, 32'd0); cycles(1);
    chk("misaligned load fault", {1'b0, last_err[1], last_rdata[1]}, {2'b01, 32'd0});
    issue(1, 1'b1, 2'd1, 1'b0, 32'h1F, 32'h00005566); cycles(1);
    lit("misaligned store err", {31'd0, last_err[1]}, 32'd1);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h1C, 32'd0); cycles(1);
    lit("unchanged 0x1C", last_rdata[1], 32'hCCCCCCCC);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0); cycles(1);
    lit("unchanged 0x20", last_rdata[1], 32'hDDDDDDDD);

    // Range and size boundaries.
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0); cycles(1);
    lit("top word ok", {31'd0, last_err[0]}, 32'd0);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h1FF, 32'd0); cycles(1);
    lit("half 0x1FF err", {31'd0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0); cycles(1);
    lit("word 0xFFFFFFFE err", {31'd0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0);
    issue(0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h12345678); cycles(1);
    lit("size 11 err", {31'd0, last_err[0]}, 32'd1);

    // Reset in the middle of a split store.
    issue(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h22222222);
    cycles(2);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2;
    req_unsigned[0] = 1'b0; req_addr[0] = 32'h42; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #2;
    chk("split entered", {33'd0, req_ready[0]}, 34'd0);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset mid-split outputs", {req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0][30:0]},
        {1'b1, 33'd0});
    lit("reset mid-split rdata", rsp_rdata[0], 32'd0);
    mm[0][66] = 8'h0D;
    mm[0][67] = 8'hF0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("no rsp for aborted split", {1'b0, rsp_valid[0], rsp_rdata[0]}, 34'd0);
    reset = 1'b0;
    cycles(1);
    chk_en = 1'b1;
    issue(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0); cycles(1);
    lit("low word committed", last_rdata[0], 32'hF00D1111);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0); cycles(1);
    lit("high word untouched", last_rdata[0], 32'h22222222);

    // Randomised traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      repeat (300) begin
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEMB + 7));
        issue(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        if ($urandom_range(0, 3) == 0) cycles(1);
      end
    end

    cycles(4);
    chk("queues drained", {2'b00, 32'(q0.size() + q1.size())}, 34'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
